read_distributor: RTL and testbench

READ_DISTRIBUTOR -- requirements
Module: read_distributor

---
 rtl/sram_ctl_pkg.sv | 15 +
 rtl/read_out_stage.sv | 48 ++++
 rtl/read_distributor.sv | 111 +++++++++++
 tb/tb_read_distributor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctl_pkg.sv
// Shared SRAM controller types: FSM encoding, port index width, default widths.
// Used by the read distributor and the write-side arbiter.
package sram_ctl_pkg;

    localparam int PORT_W        = 4;
    localparam int DEF_NUM_PORTS = 16;
    localparam int DEF_DATA_W    = 256;
    localparam int PKT_CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } rd_state_t;

endpackage

// File: rtl/read_out_stage.sv
// Single output register stage for the read distributor: payload, markers,
// one-hot valid and hold-while-stalled logic.
module read_out_stage
    import sram_ctl_pkg::*;
#(
    parameter int num_of_ports = DEF_NUM_PORTS,
    parameter int data_w       = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [PORT_W-1:0]       load_port,
    input  logic [data_w-1:0]       load_data,
    input  logic                    load_sop,
    input  logic                    load_eop,
    input  logic [num_of_ports-1:0] out_ready,
    output logic [data_w-1:0]       out_data,
    output logic [num_of_ports-1:0] out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    free
);

    logic                    consume;
    logic [num_of_ports-1:0] one_hot;

    // valid is one-hot, so masking with out_ready selects the held port's ready
    assign consume = |(out_valid & out_ready);
    assign free    = ~|out_valid | consume;
    assign one_hot = {{(num_of_ports-1){1'b0}}, 1'b1} << load_port;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= one_hot;
            out_sop   <= load_sop;
            out_eop   <= load_eop;
        end else if (consume) begin
            out_valid <= '0;
        end
    end

endmodule

// File: rtl/read_distributor.sv
// Routes SRAM read packets to one of num_of_ports outputs via an IDLE/XFER FSM.
// Optional per-port packet counters under READ_DIST_PKT_CNT_EN.
module read_distributor
    import sram_ctl_pkg::*;
#(
    parameter int num_of_ports       = DEF_NUM_PORTS,
    parameter int arbiter_data_width = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic                          rd_sop,
    input  logic                          rd_eop,
    input  logic [PORT_W-1:0]             rd_port,
    input  logic [arbiter_data_width-1:0] rd_data,
    output logic [arbiter_data_width-1:0] out_data,
    output logic [num_of_ports-1:0]       out_valid,
    input  logic [num_of_ports-1:0]       out_ready,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          transfering,
    output logic                          err
`ifdef READ_DIST_PKT_CNT_EN
    ,
    output logic [num_of_ports*PKT_CNT_W-1:0] pkt_cnt
`endif
);

    rd_state_t         state, state_nxt;
    logic [PORT_W-1:0] cur_port, cur_port_nxt;
    logic [PORT_W-1:0] route_port;
    logic              accept;
    logic              fwd, fwd_sop, err_nxt;

    assign accept      = rd_valid & rd_ready;
    assign transfering = (state == XFER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_port <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_port <= cur_port_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_port_nxt = cur_port;
        route_port   = cur_port;
        fwd          = 1'b0;
        fwd_sop      = 1'b0;
        err_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && rd_sop) begin
                    fwd          = 1'b1;
                    fwd_sop      = 1'b1;
                    route_port   = rd_port;
                    cur_port_nxt = rd_port;
                    if (!rd_eop) state_nxt = XFER;
                end else if (accept) begin
                    err_nxt = 1'b1;
                end
            end
            XFER: begin
                if (accept) begin
                    fwd     = 1'b1;
                    err_nxt = rd_sop;
                    if (rd_eop) state_nxt = IDLE;
                end
            end
        endcase
    end

    read_out_stage #(
        .num_of_ports (num_of_ports),
        .data_w       (arbiter_data_width)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (fwd),
        .load_port (route_port),
        .load_data (rd_data),
        .load_sop  (fwd_sop),
        .load_eop  (rd_eop),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .free      (rd_ready)
    );

`ifdef READ_DIST_PKT_CNT_EN
    for (genvar i = 0; i < num_of_ports; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <= '0;
            else if (out_valid[i] && out_ready[i] && out_eop)
                pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <=
                    pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_read_distributor.sv
// Directed self-checking bench for read_distributor.
// Set READ_DIST_PKT_CNT_EN to also exercise the packet counters.
module tb_read_distributor;

    localparam int NP = 16;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic          rd_sop = 1'b0;
    logic          rd_eop = 1'b0;
    logic [3:0]    rd_port = '0;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic [NP-1:0] out_valid;
    logic [NP-1:0] out_ready = '1;
    logic          out_sop;
    logic          out_eop;
    logic          transfering;
    logic          err;
`ifdef READ_DIST_PKT_CNT_EN
    logic [NP*16-1:0] pkt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    read_distributor #(
        .num_of_ports       (NP),
        .arbiter_data_width (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_sop      (rd_sop),
        .rd_eop      (rd_eop),
        .rd_port     (rd_port),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .transfering (transfering),
        .err         (err)
`ifdef READ_DIST_PKT_CNT_EN
        ,
        .pkt_cnt     (pkt_cnt)
`endif
    );

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [3:0] p, input logic [DW-1:0] d);
        rd_valid = v;
        rd_sop   = s;
        rd_eop   = e;
        rd_port  = p;
        rd_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, '0);
        tick();
        tick();
        n_checks++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL reset_valid got %h want 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_checks++; if ({out_sop, out_eop, err, transfering} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {out_sop, out_eop, err, transfering}); end
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = '1;
        drive(1, 1, 0, 4'd5, DW'(1));
        tick();
        n_checks++; if (out_valid !== 16'h0020 || out_sop !== 1'b1 || out_eop !== 1'b0 || out_data !== DW'(1)) begin n_fail++; $display("FAIL basic_b1 got v=%h s=%b e=%b d=%0h want v=0020 s=1 e=0 d=1", out_valid, out_sop, out_eop, out_data); end
        n_checks++; if (transfering !== 1'b1) begin n_fail++; $display("FAIL basic_xfer1 got %b want 1", transfering); end
        drive(1, 0, 0, 4'd0, DW'(2));
        tick();
        n_checks++; if (out_valid !== 16'h0020 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data !== DW'(2)) begin n_fail++; $display("FAIL basic_b2 got v=%h s=%b e=%b d=%0h want v=0020 s=0 e=0 d=2", out_valid, out_sop, out_eop, out_data); end
        n_checks++; if (transfering !== 1'b1) begin n_fail++; $display("FAIL basic_xfer2 got %b want 1", transfering); end
        drive(1, 0, 1, 4'd0, DW'(3));
        tick();
        n_checks++; if (out_valid !== 16'h0020 || out_sop !== 1'b0 || out_eop !== 1'b1 || out_data !== DW'(3)) begin n_fail++; $display("FAIL basic_b3 got v=%h s=%b e=%b d=%0h want v=0020 s=0 e=1 d=3", out_valid, out_sop, out_eop, out_data); end
        n_checks++; if (transfering !== 1'b0) begin n_fail++; $display("FAIL basic_xfer3 got %b want 0", transfering); end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL basic_drain got %h want 0", out_valid); end
    endtask

    task automatic test_single();
        drive(1, 1, 1, 4'd15, DW'(16'hBEEF));
        tick();
        n_checks++; if (out_valid !== 16'h8000 || out_sop !== 1'b1 || out_eop !== 1'b1 || out_data !== DW'(16'hBEEF)) begin n_fail++; $display("FAIL single_beat got v=%h s=%b e=%b d=%0h want v=8000 s=1 e=1 d=beef", out_valid, out_sop, out_eop, out_data); end
        n_checks++; if (transfering !== 1'b0) begin n_fail++; $display("FAIL single_xfer got %b want 0", transfering); end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (out_valid !== 16'h0 || transfering !== 1'b0) begin n_fail++; $display("FAIL single_after got v=%h t=%b want v=0 t=0", out_valid, transfering); end
    endtask

    task automatic test_stall();
        out_ready = '1;
        drive(1, 1, 0, 4'd2, DW'(16'h10));
        tick();
        n_checks++; if (out_valid !== 16'h0004 || out_data !== DW'(16'h10)) begin n_fail++; $display("FAIL stall_b1 got v=%h d=%0h want v=0004 d=10", out_valid, out_data); end
        drive(1, 0, 0, 4'd0, DW'(16'h11));
        tick();
        n_checks++; if (out_data !== DW'(16'h11)) begin n_fail++; $display("FAIL stall_b2 got %0h want 11", out_data); end
        // other ports stay ready to show they do not release the stall
        out_ready = 16'hFFFB;
        drive(1, 0, 0, 4'd0, DW'(16'h12));
        #1;
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_a got %b want 0", rd_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_valid !== 16'h0004 || out_data !== DW'(16'h11)) begin n_fail++; $display("FAIL stall_hold_b2 got v=%h d=%0h want v=0004 d=11", out_valid, out_data); end
        end
        out_ready = '1;
        #1;
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_b got %b want 1", rd_ready); end
        tick();
        n_checks++; if (out_valid !== 16'h0004 || out_data !== DW'(16'h12)) begin n_fail++; $display("FAIL stall_b3 got v=%h d=%0h want v=0004 d=12", out_valid, out_data); end
        out_ready = 16'hFFFB;
        drive(1, 0, 1, 4'd0, DW'(16'h13));
        #1;
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_c got %b want 0", rd_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_data !== DW'(16'h12) || out_eop !== 1'b0) begin n_fail++; $display("FAIL stall_hold_b3 got d=%0h e=%b want d=12 e=0", out_data, out_eop); end
        end
        out_ready = '1;
        tick();
        n_checks++; if (out_valid !== 16'h0004 || out_data !== DW'(16'h13) || out_eop !== 1'b1) begin n_fail++; $display("FAIL stall_b4 got v=%h d=%0h e=%b want v=0004 d=13 e=1", out_valid, out_data, out_eop); end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (out_valid !== 16'h0 || transfering !== 1'b0) begin n_fail++; $display("FAIL stall_drain got v=%h t=%b want 0 0", out_valid, transfering); end
    endtask

    task automatic test_err();
        drive(1, 0, 0, 4'd3, DW'(8'hA5));
        tick();
        n_checks++; if (out_valid !== 16'h0 || err !== 1'b1) begin n_fail++; $display("FAIL err_nosop got v=%h err=%b want v=0 err=1", out_valid, err); end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (err !== 1'b0 || out_valid !== 16'h0) begin n_fail++; $display("FAIL err_pulse got err=%b v=%h want 0 0", err, out_valid); end
        drive(1, 1, 0, 4'd7, DW'(1));
        tick();
        n_checks++; if (out_valid !== 16'h0080 || err !== 1'b0) begin n_fail++; $display("FAIL err_pkt_b1 got v=%h err=%b want 0080 0", out_valid, err); end
        drive(1, 1, 0, 4'd1, DW'(2));
        tick();
        n_checks++; if (out_valid !== 16'h0080 || out_sop !== 1'b0 || err !== 1'b1 || out_data !== DW'(2)) begin n_fail++; $display("FAIL err_midsop got v=%h s=%b err=%b d=%0h want 0080 0 1 2", out_valid, out_sop, err, out_data); end
        drive(1, 0, 1, 4'd0, DW'(3));
        tick();
        n_checks++; if (out_valid !== 16'h0080 || out_eop !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL err_pkt_end got v=%h e=%b err=%b want 0080 1 0", out_valid, out_eop, err); end
        drive(0, 0, 0, 0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] exp_v [4];
        logic [3:0]    ports [4];
        exp_v = '{16'h0001, 16'h0001, 16'h0200, 16'h0200};
        ports = '{4'd0, 4'd0, 4'd9, 4'd9};
        for (int i = 0; i < 4; i++) begin
            drive(1, (i % 2) == 0, (i % 2) == 1, ports[i], DW'(i + 32));
            tick();
            n_checks++; if (out_valid !== exp_v[i] || out_data !== DW'(i + 32) || out_sop !== ((i % 2) == 0) || out_eop !== ((i % 2) == 1)) begin n_fail++; $display("FAIL b2b_beat%0d got v=%h d=%0h s=%b e=%b want v=%h", i, out_valid, out_data, out_sop, out_eop, exp_v[i]); end
        end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (out_valid !== 16'h0) begin n_fail++; $display("FAIL b2b_drain got %h want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 4'd4, DW'(7));
        tick();
        drive(1, 0, 0, 4'd0, DW'(8));
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 16'h0 || out_data !== '0 || transfering !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs got v=%h d=%0h t=%b err=%b want all 0", out_valid, out_data, transfering, err); end
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy got %b want 1", rd_ready); end
        rst = 1'b1;
        drive(1, 0, 0, 4'd0, DW'(9));
        tick();
        n_checks++; if (out_valid !== 16'h0 || err !== 1'b1) begin n_fail++; $display("FAIL rstmid_b3 got v=%h err=%b want 0 1", out_valid, err); end
        drive(1, 0, 1, 4'd0, DW'(10));
        tick();
        n_checks++; if (out_valid !== 16'h0 || err !== 1'b1) begin n_fail++; $display("FAIL rstmid_b4 got v=%h err=%b want 0 1", out_valid, err); end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (err !== 1'b0 || transfering !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got err=%b t=%b want 0 0", err, transfering); end
    endtask

`ifdef READ_DIST_PKT_CNT_EN
    task automatic test_pkt_cnt();
        n_checks++; if (pkt_cnt[5*16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL cnt_start got %0d want 0", pkt_cnt[5*16 +: 16]); end
        out_ready = '1;
        for (int p = 0; p < 3; p++) begin
            drive(1, 1, 0, 4'd5, DW'(1));
            tick();
            drive(1, 0, 0, 4'd0, DW'(2));
            tick();
            drive(1, 0, 1, 4'd0, DW'(3));
            tick();
        end
        drive(0, 0, 0, 0, '0);
        tick();
        n_checks++; if (pkt_cnt[5*16 +: 16] !== 16'd3) begin n_fail++; $display("FAIL cnt_port5 got %0d want 3", pkt_cnt[5*16 +: 16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_err();
        test_back_to_back();
        test_reset_mid();
`ifdef READ_DIST_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
